wb_regfile: RTL

//  Write-back consumer of the MEM/WB pipeline register. Selects the write-back value (ALU result, load data or CP0 data),

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/gpr_array.sv | 46 ++++
 rtl/wb_regfile.sv | 91 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU defaults, register-zero index and write-back source encoding
package cpu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 32;
  localparam int REG_ZERO   = 0;

  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'd0,
    WB_SRC_MEM = 2'd1,
    WB_SRC_CP0 = 2'd2
  } wb_src_e;

  // CP0 data wins over load data, which wins over the ALU result.
  function automatic wb_src_e wb_src_sel(input logic mfc0, input logic memtoreg);
    if (mfc0)
      return WB_SRC_CP0;
    else if (memtoreg)
      return WB_SRC_MEM;
    else
      return WB_SRC_ALU;
  endfunction

endpackage

// File: rtl/gpr_array.sv
// rtl/gpr_array.sv - GPR storage with one write port and two write-bypassed combinational read ports
module gpr_array
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (wen && waddr != ZERO_IDX) begin
      mem[waddr] <= wdata;
    end
  end

  // Register zero is forced here too so a bypass to index 0 can never leak data.
  always_comb begin
    rs_data = '0;
    if (rs_addr != ZERO_IDX)
      rs_data = (wen && rs_addr == waddr) ? wdata : mem[rs_addr];
  end

  always_comb begin
    rt_data = '0;
    if (rt_addr != ZERO_IDX)
      rt_data = (wen && rt_addr == waddr) ? wdata : mem[rt_addr];
  end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back select, GPR commit and retire counter; WB_REGFILE_TRACE_EN adds debug trace outputs
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic              wb_regwrite,
  input  logic              wb_memtoreg,
  input  logic              wb_mfc0,
  input  logic [DATA_W-1:0] wb_aluout,
  input  logic [DATA_W-1:0] wb_rdata,
  input  logic [DATA_W-1:0] wb_except_data,
  input  logic [31:0]       wb_pc,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [CNT_W-1:0]  retire_cnt
`ifdef WB_REGFILE_TRACE_EN
  ,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
`endif
);

  wb_src_e           wb_src;
  logic [DATA_W-1:0] wdata;
  logic              wen;

  always_comb begin
    wb_src = wb_src_sel(wb_mfc0, wb_memtoreg);
    wdata  = wb_aluout;
    case (wb_src)
      WB_SRC_CP0: wdata = wb_except_data;
      WB_SRC_MEM: wdata = wb_rdata;
      default:    wdata = wb_aluout;
    endcase
  end

  // Writes in the reset cycle are dropped, so the bypass must not see them either.
  assign wen = wb_valid & wb_regwrite & (wb_rd != ADDR_W'(REG_ZERO)) & ~reset;

  gpr_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_gpr_array (
    .clk     (clk),
    .reset   (reset),
    .wen     (wen),
    .waddr   (wb_rd),
    .wdata   (wdata),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  always_ff @(posedge clk) begin
    if (reset)
      retire_cnt <= '0;
    else if (wb_valid)
      retire_cnt <= retire_cnt + CNT_W'(1);
  end

`ifdef WB_REGFILE_TRACE_EN
  always_comb begin
    debug_wb_pc       = '0;
    debug_wb_rf_wen   = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    if (!reset) begin
      debug_wb_pc       = wb_pc;
      debug_wb_rf_wen   = {4{wen}};
      debug_wb_rf_wnum  = wb_rd;
      debug_wb_rf_wdata = wdata;
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^wb_pc;
`endif

endmodule
